// File: rtl/fetch_decode_if.sv
// fetch_decode_if: bundles the instruction-memory req/ack port and the
// Core-facing decode/control signals of the fetch_decode sequencer.
// master = the sequencer, slave = instruction memory plus Core datapath.
interface fetch_decode_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        isZero;
  logic [31:0] Da;
  logic [4:0]  Rs;
  logic [4:0]  Rt;
  logic [4:0]  Rd;
  logic [15:0] imm;
  logic [31:0] addedPC;
  logic [1:0]  RegDst;
  logic        RegWr;
  logic        MemWr;
  logic        ALUSrc;
  logic [1:0]  MemToReg;
  logic [2:0]  ALUCntrl;
  logic [31:0] pc;
  logic        exec;
  logic        halted;

  modport master (
    output imem_addr, imem_req,
    input  imem_ack, imem_data, isZero, Da,
    output Rs, Rt, Rd, imm, addedPC, RegDst, RegWr, MemWr, ALUSrc,
           MemToReg, ALUCntrl, pc, exec, halted
  );

  modport slave (
    input  imem_addr, imem_req,
    output imem_ack, imem_data, isZero, Da,
    input  Rs, Rt, Rd, imm, addedPC, RegDst, RegWr, MemWr, ALUSrc,
           MemToReg, ALUCntrl, pc, exec, halted
  );
endinterface

// File: rtl/fetch_decode.sv
// fetch_decode: PC holder, instruction fetcher and decoder feeding the
// single-cycle Core datapath. One instruction takes FETCH (>= 1 cycle)
// followed by exactly one EXEC cycle in which RegWr/MemWr are qualified.
// Optional feature macro: FETCH_ILLEGAL_TRAP_EN -- when defined, an illegal
// instruction halts the sequencer (HALT until reset); when undefined it
// executes as a NOP and `halted` is tied low.
module fetch_decode #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic           CLK,
  input  logic           RST_N,
  fetch_decode_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
`ifdef FETCH_ILLEGAL_TRAP_EN
  localparam logic [1:0] S_HALT  = 2'd3;
`endif

  // Retry fires on the cycle the counter has seen ACK_TIMEOUT unacked cycles.
  localparam logic [7:0] RETRY_LAST = 8'(ACK_TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [7:0]  r_retryCnt;
  logic        r_drop;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [1:0]  w_regDst;
  logic        w_regWr;
  logic        w_memWr;
  logic        w_aluSrc;
  logic [1:0]  w_memToReg;
  logic [2:0]  w_aluCntrl;
  logic        w_legal;
  logic        w_isBne;
  logic        w_isJump;
  logic        w_isJr;
  logic        w_exec;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_branchOff;
  logic [31:0] w_nextPc;

  assign w_opcode    = r_ir[31:26];
  assign w_funct     = r_ir[5:0];
  assign w_exec      = (r_state == S_EXEC);
  assign w_pcPlus4   = r_pc + 32'd4;
  assign w_branchOff = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

  // Decode IR into Core control fields; unlisted encodings stay all-zero/illegal.
  always_comb begin
    w_regDst   = 2'b00;
    w_regWr    = 1'b0;
    w_memWr    = 1'b0;
    w_aluSrc   = 1'b0;
    w_memToReg = 2'b00;
    w_aluCntrl = 3'b000;
    w_legal    = 1'b0;
    w_isBne    = 1'b0;
    w_isJump   = 1'b0;
    w_isJr     = 1'b0;
    case (w_opcode)
      6'h08: begin
        w_regDst = 2'b01; w_aluSrc = 1'b1; w_regWr = 1'b1; w_legal = 1'b1;
      end
      6'h0E: begin
        w_regDst = 2'b01; w_aluSrc = 1'b1; w_aluCntrl = 3'b010;
        w_regWr = 1'b1; w_legal = 1'b1;
      end
      6'h23: begin
        w_regDst = 2'b01; w_aluSrc = 1'b1; w_memToReg = 2'b01;
        w_regWr = 1'b1; w_legal = 1'b1;
      end
      6'h2B: begin
        w_aluSrc = 1'b1; w_memWr = 1'b1; w_legal = 1'b1;
      end
      6'h05: begin
        w_aluCntrl = 3'b001; w_isBne = 1'b1; w_legal = 1'b1;
      end
      6'h02: begin
        w_isJump = 1'b1; w_legal = 1'b1;
      end
      6'h03: begin
        w_regDst = 2'b10; w_memToReg = 2'b10; w_regWr = 1'b1;
        w_isJump = 1'b1; w_legal = 1'b1;
      end
      6'h00: begin
        if (r_ir == 32'd0) begin
          w_legal = 1'b1;
        end else begin
          case (w_funct)
            6'h20: begin w_regWr = 1'b1; w_legal = 1'b1; end
            6'h22: begin w_aluCntrl = 3'b001; w_regWr = 1'b1; w_legal = 1'b1; end
            6'h2A: begin w_aluCntrl = 3'b011; w_regWr = 1'b1; w_legal = 1'b1; end
            6'h08: begin w_isJr = 1'b1; w_legal = 1'b1; end
            default: w_legal = 1'b0;
          endcase
        end
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Select the PC for the next instruction; all sums wrap mod 2^32.
  always_comb begin
    w_nextPc = w_pcPlus4;
    if (w_isBne && !bus.isZero) begin
      w_nextPc = w_pcPlus4 + w_branchOff;
    end else if (w_isJump) begin
      w_nextPc = {w_pcPlus4[31:28], r_ir[25:0], 2'b00};
    end else if (w_isJr) begin
      w_nextPc = bus.Da;
    end
  end

  // Sequencer: IDLE -> FETCH (with timed retry) -> EXEC -> FETCH, optional HALT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_ir       <= 32'd0;
      r_retryCnt <= 8'd0;
      r_drop     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_retryCnt <= 8'd0;
          r_drop     <= 1'b0;
        end
        S_FETCH: begin
          if (r_drop) begin
            r_drop <= 1'b0;
          end else if (bus.imem_ack) begin
            r_ir       <= bus.imem_data;
            r_retryCnt <= 8'd0;
            r_state    <= S_EXEC;
          end else if (r_retryCnt == RETRY_LAST) begin
            r_drop     <= 1'b1;
            r_retryCnt <= 8'd0;
          end else begin
            r_retryCnt <= r_retryCnt + 8'd1;
          end
        end
        S_EXEC: begin
`ifdef FETCH_ILLEGAL_TRAP_EN
          if (!w_legal) begin
            r_state <= S_HALT;
          end else begin
            r_pc    <= w_nextPc;
            r_state <= S_FETCH;
          end
`else
          r_pc    <= w_nextPc;
          r_state <= S_FETCH;
`endif
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.imem_req  = (r_state == S_FETCH) && !r_drop;
  assign bus.Rs        = r_ir[25:21];
  assign bus.Rt        = r_ir[20:16];
  assign bus.Rd        = r_ir[15:11];
  assign bus.imm       = r_ir[15:0];
  assign bus.addedPC   = w_pcPlus4;
  assign bus.RegDst    = w_regDst;
  assign bus.RegWr     = w_exec && w_regWr && w_legal;
  assign bus.MemWr     = w_exec && w_memWr && w_legal;
  assign bus.ALUSrc    = w_aluSrc;
  assign bus.MemToReg  = w_memToReg;
  assign bus.ALUCntrl  = w_aluCntrl;
  assign bus.pc        = r_pc;
  assign bus.exec      = w_exec;
`ifdef FETCH_ILLEGAL_TRAP_EN
  assign bus.halted    = (r_state == S_HALT);
`else
  assign bus.halted    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed and randomized checks of fetch_decode against an
// instruction-level reference model (decode table + next-PC arithmetic).
module tb_fetch_decode;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] mpc;

  always #5 clk = ~clk;

  fetch_decode_if ifc ();

  fetch_decode #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(4)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (ifc)
  );

  typedef struct packed {
    logic [1:0] regDst;
    logic       regWr;
    logic       memWr;
    logic       aluSrc;
    logic [1:0] memToReg;
    logic [2:0] alu;
  } ctl_t;

  // Reference decode straight from the instruction table.
  function automatic ctl_t ref_ctl(input logic [31:0] ir);
    ctl_t c = '0;
    case (ir[31:26])
      6'h08: c = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 3'b000};
      6'h0E: c = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 3'b010};
      6'h23: c = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 3'b000};
      6'h2B: c = '{2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000};
      6'h05: c = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 3'b001};
      6'h03: c = '{2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 3'b000};
      6'h00: begin
        if (ir[5:0] == 6'h20 && ir != 0) c = '{2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000};
        if (ir[5:0] == 6'h22) c = '{2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 3'b001};
        if (ir[5:0] == 6'h2A) c = '{2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 3'b011};
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Reference next PC using plain 32-bit arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ir,
                                           input logic iz, input logic [31:0] da);
    logic signed [31:0] off;
    off = 32'($signed(ir[15:0]));
    if (ir[31:26] == 6'h05 && !iz) return pc + 32'd4 + 32'(off * 4);
    if (ir[31:26] == 6'h02 || ir[31:26] == 6'h03)
      return ((pc + 32'd4) & 32'hF000_0000) | (32'(ir[25:0]) * 32'd4);
    if (ir[31:26] == 6'h00 && ir[5:0] == 6'h08) return da;
    return pc + 32'd4;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // From a negedge in FETCH: present ir after `delay` unacked cycles; returns at EXEC negedge.
  task automatic fetch_exec(input logic [31:0] ir, input logic iz, input logic [31:0] da,
                            input int delay);
    ifc.imem_data = ir;
    ifc.isZero    = iz;
    ifc.Da        = da;
    ifc.imem_ack  = 1'b0;
    repeat (delay) step();
    ifc.imem_ack = 1'b1;
    step();
    ifc.imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.imem_ack = 1'b0; ifc.imem_data = 32'd0; ifc.isZero = 1'b0; ifc.Da = 32'd0;
    repeat (3) @(negedge clk);
    total++; if (ifc.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req got=%b want=0", ifc.imem_req); end
    total++; if (ifc.pc !== 32'd0) begin bad++; $display("[TB] FAIL reset_pc got=%h want=0", ifc.pc); end
    total++; if ({ifc.exec, ifc.halted, ifc.RegWr, ifc.MemWr} !== 4'b0) begin bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {ifc.exec, ifc.halted, ifc.RegWr, ifc.MemWr}); end
    total++; if ({ifc.Rs, ifc.imm} !== 21'd0) begin bad++; $display("[TB] FAIL reset_ir got=%h want=0", {ifc.Rs, ifc.imm}); end
    rst_n = 1'b1;
    #1;
    total++; if (ifc.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL idle_req got=%b want=0", ifc.imem_req); end
    @(negedge clk);
    step();
    total++; if (ifc.imem_req !== 1'b1) begin bad++; $display("[TB] FAIL req_rise got=%b want=1", ifc.imem_req); end
    mpc = 32'd0;
  endtask

  task automatic test_addi();
    fetch_exec(32'h2001_0005, 1'b0, 32'd0, 0);
    total++; if (ifc.exec !== 1'b1) begin bad++; $display("[TB] FAIL addi_exec got=%b want=1", ifc.exec); end
    total++; if ({ifc.RegDst, ifc.ALUSrc, ifc.RegWr, ifc.MemWr} !== 5'b01110) begin bad++; $display("[TB] FAIL addi_ctl got=%b want=01110", {ifc.RegDst, ifc.ALUSrc, ifc.RegWr, ifc.MemWr}); end
    total++; if ({ifc.Rt, ifc.imm, ifc.pc} !== {5'd1, 16'd5, 32'd0}) begin bad++; $display("[TB] FAIL addi_fields got=%h want=%h", {ifc.Rt, ifc.imm, ifc.pc}, {5'd1, 16'd5, 32'd0}); end
    step();
    total++; if (ifc.pc !== 32'd4) begin bad++; $display("[TB] FAIL addi_pc got=%h want=4", ifc.pc); end
    total++; if ({ifc.exec, ifc.RegWr, ifc.imem_req} !== 3'b001) begin bad++; $display("[TB] FAIL addi_after got=%b want=001", {ifc.exec, ifc.RegWr, ifc.imem_req}); end
    mpc = 32'd4;
  endtask

  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      fetch_exec(32'h0800_0004, 1'b0, 32'd0, 1);
      step();
      total++; if (ifc.pc !== 32'h10) begin bad++; $display("[TB] FAIL j_pc got=%h want=10", ifc.pc); end
      fetch_exec(32'h1611_0003, k[0], 32'd0, 0);
      total++; if ({ifc.RegWr, ifc.MemWr, ifc.ALUSrc, ifc.ALUCntrl} !== 6'b000001) begin bad++; $display("[TB] FAIL bne_ctl got=%b want=000001", {ifc.RegWr, ifc.MemWr, ifc.ALUSrc, ifc.ALUCntrl}); end
      step();
      total++; if (ifc.pc !== ((k == 0) ? 32'h20 : 32'h14)) begin bad++; $display("[TB] FAIL bne_pc iz=%0d got=%h want=%h", k, ifc.pc, (k == 0) ? 32'h20 : 32'h14); end
    end
    mpc = 32'h14;
  endtask

  task automatic test_jal_jr();
    fetch_exec(32'h03E0_0008, 1'b0, 32'h8, 2);
    total++; if ({ifc.RegWr, ifc.MemWr, ifc.Rs} !== {2'b00, 5'd31}) begin bad++; $display("[TB] FAIL jr_ctl got=%b want=0011111", {ifc.RegWr, ifc.MemWr, ifc.Rs}); end
    step();
    total++; if (ifc.pc !== 32'h8) begin bad++; $display("[TB] FAIL jr8_pc got=%h want=8", ifc.pc); end
    fetch_exec(32'h0C00_0040, 1'b0, 32'd0, 0);
    total++; if ({ifc.RegDst, ifc.MemToReg, ifc.RegWr} !== 5'b10101) begin bad++; $display("[TB] FAIL jal_ctl got=%b want=10101", {ifc.RegDst, ifc.MemToReg, ifc.RegWr}); end
    total++; if (ifc.addedPC !== 32'hC) begin bad++; $display("[TB] FAIL jal_addedpc got=%h want=c", ifc.addedPC); end
    step();
    total++; if (ifc.pc !== 32'h100) begin bad++; $display("[TB] FAIL jal_pc got=%h want=100", ifc.pc); end
    fetch_exec(32'h03E0_0008, 1'b0, 32'hC, 0);
    step();
    total++; if (ifc.pc !== 32'hC) begin bad++; $display("[TB] FAIL jr_pc got=%h want=c", ifc.pc); end
    mpc = 32'hC;
  endtask

  task automatic test_wrap();
    fetch_exec(32'h03E0_0008, 1'b0, 32'hFFFF_FFFC, 0);
    step();
    fetch_exec(32'h2001_0005, 1'b0, 32'd0, 0);
    total++; if (ifc.addedPC !== 32'd0) begin bad++; $display("[TB] FAIL wrap_added got=%h want=0", ifc.addedPC); end
    step();
    total++; if (ifc.pc !== 32'd0) begin bad++; $display("[TB] FAIL wrap_pc got=%h want=0", ifc.pc); end
    fetch_exec(32'h03E0_0008, 1'b0, 32'h0000_0103, 0);
    step();
    total++; if (ifc.pc !== 32'h103) begin bad++; $display("[TB] FAIL jr_lowbits got=%h want=103", ifc.pc); end
    fetch_exec(32'h03E0_0008, 1'b0, 32'h40, 0);
    step();
    mpc = 32'h40;
  endtask

  task automatic test_retry();
    logic [31:0] p;
    p = ifc.pc;
    for (int i = 0; i < 10; i++) begin
      total++; if (ifc.imem_req !== ((i % 5) != 4)) begin bad++; $display("[TB] FAIL retry_req i=%0d got=%b want=%b", i, ifc.imem_req, (i % 5) != 4); end
      total++; if ({ifc.exec, ifc.imem_addr} !== {1'b0, p}) begin bad++; $display("[TB] FAIL retry_addr i=%0d got=%h want=%h", i, {ifc.exec, ifc.imem_addr}, {1'b0, p}); end
      ifc.imem_data = 32'h2001_0005;
      ifc.imem_ack  = (i == 4);
      step();
    end
    ifc.imem_ack = 1'b0;
    fetch_exec(32'h2001_0005, 1'b0, 32'd0, 0);
    total++; if (ifc.exec !== 1'b1) begin bad++; $display("[TB] FAIL retry_exec got=%b want=1", ifc.exec); end
    step();
    total++; if (ifc.pc !== p + 32'd4) begin bad++; $display("[TB] FAIL retry_pc got=%h want=%h", ifc.pc, p + 32'd4); end
    mpc = p + 32'd4;
  endtask

  task automatic test_random();
    logic [5:0]  ops [8] = '{6'h08, 6'h0E, 6'h23, 6'h2B, 6'h05, 6'h02, 6'h03, 6'h00};
    logic [5:0]  fns [4] = '{6'h20, 6'h22, 6'h2A, 6'h08};
    logic [31:0] ir, da, expPc;
    logic        iz;
    ctl_t        ec;
    for (int n = 0; n < 40; n++) begin
      ir = $urandom;
      ir[31:26] = ops[$urandom_range(0, 7)];
      if (ir[31:26] == 6'h00) ir[5:0] = fns[$urandom_range(0, 3)];
      if (n % 10 == 9) ir = 32'd0;
      iz = 1'($urandom_range(0, 1));
      da = $urandom;
      ec = ref_ctl(ir);
      expPc = ref_next(mpc, ir, iz, da);
      total++; if (ifc.RegWr !== 1'b0 || ifc.MemWr !== 1'b0) begin bad++; $display("[TB] FAIL rnd_fetchwr n=%0d got=%b%b want=00", n, ifc.RegWr, ifc.MemWr); end
      fetch_exec(ir, iz, da, $urandom_range(0, 3));
      total++; if ({ifc.RegDst, ifc.RegWr, ifc.MemWr, ifc.ALUSrc, ifc.MemToReg, ifc.ALUCntrl} !== ec) begin bad++; $display("[TB] FAIL rnd_ctl n=%0d ir=%h got=%b want=%b", n, ir, {ifc.RegDst, ifc.RegWr, ifc.MemWr, ifc.ALUSrc, ifc.MemToReg, ifc.ALUCntrl}, ec); end
      total++; if ({ifc.Rs, ifc.Rt, ifc.Rd, ifc.imm, ifc.addedPC} !== {ir[25:21], ir[20:16], ir[15:11], ir[15:0], mpc + 32'd4}) begin bad++; $display("[TB] FAIL rnd_fields n=%0d ir=%h got=%h want=%h", n, ir, {ifc.Rs, ifc.Rt, ifc.Rd, ifc.imm, ifc.addedPC}, {ir[25:21], ir[20:16], ir[15:11], ir[15:0], mpc + 32'd4}); end
      step();
      total++; if (ifc.pc !== expPc) begin bad++; $display("[TB] FAIL rnd_pc n=%0d ir=%h got=%h want=%h", n, ir, ifc.pc, expPc); end
      mpc = expPc;
    end
  endtask

  task automatic test_reset_mid_exec();
    fetch_exec(32'hAC22_0000, 1'b0, 32'd0, 0);
    total++; if (ifc.MemWr !== 1'b1) begin bad++; $display("[TB] FAIL sw_memwr got=%b want=1", ifc.MemWr); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({ifc.MemWr, ifc.RegWr, ifc.exec, ifc.imem_req} !== 4'b0) begin bad++; $display("[TB] FAIL abort_flags got=%b want=0000", {ifc.MemWr, ifc.RegWr, ifc.exec, ifc.imem_req}); end
    total++; if ({ifc.pc, ifc.Rs, ifc.Rt, ifc.imm} !== 58'd0) begin bad++; $display("[TB] FAIL abort_state got=%h want=0", {ifc.pc, ifc.Rs, ifc.Rt, ifc.imm}); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++; if (ifc.imem_req !== 1'b1) begin bad++; $display("[TB] FAIL abort_refetch got=%b want=1", ifc.imem_req); end
    mpc = 32'd0;
  endtask

  task automatic test_illegal();
    logic [31:0] p;
    p = ifc.pc;
    fetch_exec(32'hFC00_0000, 1'b0, 32'd0, 0);
    total++; if ({ifc.RegWr, ifc.MemWr} !== 2'b00) begin bad++; $display("[TB] FAIL ill_wr got=%b want=00", {ifc.RegWr, ifc.MemWr}); end
    step();
`ifdef FETCH_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      ifc.imem_ack = 1'b1;
      total++; if ({ifc.halted, ifc.imem_req, ifc.exec, ifc.pc} !== {3'b100, p}) begin bad++; $display("[TB] FAIL ill_halt i=%0d got=%h want=%h", i, {ifc.halted, ifc.imem_req, ifc.exec, ifc.pc}, {3'b100, p}); end
      step();
    end
    ifc.imem_ack = 1'b0;
`else
    total++; if ({ifc.halted, ifc.imem_req, ifc.pc} !== {2'b01, p + 32'd4}) begin bad++; $display("[TB] FAIL ill_nop got=%h want=%h", {ifc.halted, ifc.imem_req, ifc.pc}, {2'b01, p + 32'd4}); end
    fetch_exec(32'h2001_0005, 1'b0, 32'd0, 0);
    total++; if (ifc.RegWr !== 1'b1) begin bad++; $display("[TB] FAIL ill_continue got=%b want=1", ifc.RegWr); end
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_jal_jr();
    test_wrap();
    test_retry();
    test_random();
    test_reset_mid_exec();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
